// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and strobes bit_done on the last count.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_reg;

  assign bit_done = ~clear & (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || bit_done)
      count_reg <= '0;
    else
      count_reg <= count_reg + CW'(1);
  end

endmodule

// File: rtl/uart_tx_drain.sv
// Drains a show-ahead byte queue onto an 8N1 serial line.
// Define UART_TX_PARITY_EN to insert an even-parity bit (11-bit frames).
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      q_empty,
  input  logic [UART_DATA_BITS-1:0] q_dout,
  output logic                      q_pop,
  output logic                      tx,
  output logic                      busy
);

  localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_reg, state_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic [2:0]                idx_reg, idx_next;
  logic                      tx_reg, tx_next;
  logic                      busy_reg, busy_next;
  logic                      bit_done;
`ifdef UART_TX_PARITY_EN
  logic                      parity_reg, parity_next;
`endif

  // The counter is held clear in IDLE so every frame starts at count 0.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_reg == IDLE),
    .bit_done (bit_done)
  );

  assign q_pop = (state_reg == IDLE) & ~q_empty & ~reset;
  assign tx    = tx_reg;
  assign busy  = busy_reg;

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    idx_next    = idx_reg;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (q_pop) begin
          shift_next  = q_dout;
          idx_next    = '0;
          state_next  = START;
`ifdef UART_TX_PARITY_EN
          parity_next = ^q_dout;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          idx_next   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_next = shift_reg >> 1;
          if (idx_reg == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level is derived from the next state so tx changes on the same edge as the state.
  always_comb begin
    tx_next = UART_IDLE_LEVEL;
    case (state_next)
      START:  tx_next = 1'b0;
      DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_next = parity_next;
`endif
      default: tx_next = UART_IDLE_LEVEL;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      idx_reg    <= '0;
      tx_reg     <= UART_IDLE_LEVEL;
      busy_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      idx_reg    <= idx_next;
      tx_reg     <= tx_next;
      busy_reg   <= busy_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with a show-ahead 8-deep queue model.
module tb_uart_tx_drain;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int SPACING = NBITS * CPB + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       q_empty;
  logic [7:0] q_dout;
  logic       q_pop;
  logic       tx;
  logic       busy;

  logic [7:0] qmem [8];
  int push_cnt = 0;
  int pop_cnt = 0;
  int cyc = 0;
  int pop_times[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign q_empty = (push_cnt == pop_cnt);
  assign q_dout  = qmem[pop_cnt[2:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (q_pop) pop_cnt <= pop_cnt + 1;
  end

  always @(negedge clk) if (q_pop) pop_times.push_back(cyc);

  uart_tx_drain #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset   (reset),
    .q_empty (q_empty),
    .q_dout  (q_dout),
    .q_pop   (q_pop),
    .tx      (tx),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    qmem[push_cnt[2:0]] = b;
    push_cnt++;
  endtask

  // Waits (bounded) for the start bit, then samples every cycle of the frame.
  task automatic recv_frame(input logic [7:0] b, output int fall_cyc);
    logic [NBITS-1:0] exp_bits;
    logic [NBITS-1:0] rx_bits;
    int unstable;
    int n;
    exp_bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) exp_bits[k+1] = b[k];
`ifdef UART_TX_PARITY_EN
    exp_bits[9] = ^b;
`endif
    exp_bits[NBITS-1] = 1'b1;
    fall_cyc = -1;
    n = 0;
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", {31'd0, tx}, 32'd0);
    if (tx !== 1'b0) return;
    fall_cyc = cyc;
    rx_bits = '0;
    unstable = 0;
    for (int i = 0; i < NBITS * CPB; i++) begin
      if (i > 0) @(negedge clk);
      if (i % CPB == 0) rx_bits[i / CPB] = tx;
      else if (tx !== rx_bits[i / CPB]) unstable++;
    end
    check("busy_last_stop", {31'd0, busy}, 32'd1);
    check("frame_bits", 32'(rx_bits), 32'(exp_bits));
    check("data_byte", {24'd0, rx_bits[8:1]}, {24'd0, b});
    check("bit_stable", unstable, 0);
    @(negedge clk);
    check("busy_end", {31'd0, busy}, 32'd0);
    $display("frame exp %02h got %02h bits %b", b, rx_bits[8:1], rx_bits);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int fc, fc1, fc2, viol;
    logic [7:0] burst [3];
    burst[0] = 8'h00;
    burst[1] = 8'hFF;
    burst[2] = 8'h55;

    // Reset held with a non-empty queue: no pop, idle line.
    push(8'h5A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_q_pop", {31'd0, q_pop}, 32'd0);
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    reset = 1'b0;
    recv_frame(8'h5A, fc);

    // Single byte: one pop, tx falls the cycle after the pop.
    pop_times.delete();
    push(8'hA5);
    recv_frame(8'hA5, fc);
    check("a5_pop_count", pop_times.size(), 1);
    if (pop_times.size() > 0) check("a5_pop_to_fall", fc - pop_times[0], 1);

    // Three bytes at once: back-to-back frames.
    pop_times.delete();
    for (int i = 0; i < 3; i++) push(burst[i]);
    for (int i = 0; i < 3; i++) recv_frame(burst[i], fc);
    check("burst_pop_count", pop_times.size(), 3);
    if (pop_times.size() == 3) begin
      check("burst_gap01", pop_times[1] - pop_times[0], SPACING);
      check("burst_gap12", pop_times[2] - pop_times[1], SPACING);
    end
    check("burst_q_empty", {31'd0, q_empty}, 32'd1);

    // Empty queue for 200 cycles: nothing happens.
    viol = 0;
    pop_times.delete();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || q_pop !== 1'b0) viol++;
    end
    check("idle_violations", viol, 0);
    check("idle_pop_count", pop_times.size(), 0);

    // Reset during data bit 3 aborts the frame.
    push(8'h3C);
    viol = 0;
    while (tx !== 1'b0 && viol < 100) begin
      @(negedge clk);
      viol++;
    end
    check("abort_start_seen", {31'd0, tx}, 32'd0);
    repeat (17) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("abort_q_empty", {31'd0, q_empty}, 32'd1);
    push(8'h81);
    recv_frame(8'h81, fc);

    // Back-to-back pair; with parity enabled 0x07 carries parity bit 1.
    pop_times.delete();
    push(8'h07);
    push(8'h80);
    recv_frame(8'h07, fc1);
    recv_frame(8'h80, fc2);
    check("pair_fall_gap", fc2 - fc1, SPACING);
    check("pair_pop_count", pop_times.size(), 2);
    if (pop_times.size() == 2) check("pair_pop_gap", pop_times[1] - pop_times[0], SPACING);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Queue-draining UART transmitter. Pops bytes from an upstream 8-deep show-ahead byte queue and serializes each one as an 8N1 frame (optional even parity) on the programmer's host serial link. It is the reader end of the byte queue: the host-facing response path of the programmer pushes bytes into the queue, and this block empties it onto `tx`.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Legal range ≥ 2.
- `clk`  input  1  system clock; all logic rising-edge.
- `reset`  input  1  synchronous, active-high reset.
- `q_empty`  input  1  queue empty flag.
- `q_dout`  input  8  queue head byte; combinational, valid whenever `q_empty`=0.
- `q_pop`  output  1  one-cycle pop strobe; the queue advances its read pointer on the same rising edge.
- `tx`  output  1  serial line, idle high.
- `busy`  output  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: `q_pop` = (state==IDLE) & ~`q_empty` & ~`reset`, combinational. On the edge where `q_pop`=1, latch `q_dout` into the shift register, clear the baud counter, and go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: `tx`=shift[0]. Bits are sent LSB first, each held CLKS_PER_BIT cycles. Shift right after each bit. After bit 7, go to PARITY (if enabled), else STOP.
- PARITY: `tx`=XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles, then STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). The bit ends when count==CLKS_PER_BIT-1. Bit index is 3 bits.
- `q_pop` is never asserted outside IDLE. The block pops at most one byte per frame and never pops while `q_empty`=1.

## Timing
- Reset values: `tx`=1, `busy`=0, `q_pop`=0, state IDLE, counters 0. `q_pop` is forced 0 while `reset`=1.
- `tx` and `busy` are registered outputs.
- Latency: `tx` falls on the edge that consumes the pop (the cycle after `q_pop` is high).
- Frame length, start bit to end of stop bit: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- Back-to-back frames: one IDLE cycle between frames. Successive `q_pop` pulses are therefore 10·CLKS_PER_BIT+1 cycles apart (11·CLKS_PER_BIT+1 with parity).
- Queue goes empty mid-frame: no effect; the current frame completes and the block waits in IDLE.
- Reset mid-frame: next edge gives `tx`=1, `busy`=0, IDLE. The popped byte is discarded.
- `q_empty` deasserting in the same cycle as the STOP→IDLE transition: the pop occurs in the following cycle, the first IDLE cycle.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is present, even parity is sent, and the frame is 11 bits.
- `UART_TX_PARITY_EN` undefined: there is no PARITY state; DATA goes directly to STOP and the frame is 10 bits.

## Structure
- Package `uart_pkg`:
  - state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constants `UART_DATA_BITS`=8 and `UART_IDLE_LEVEL`=1'b1.
- Sub-module `uart_baud_gen`: parameter CLKS_PER_BIT; input `clear`; output `bit_done` strobe. Instantiated once.
- Shift register, bit index and FSM live in the top module.

## Test plan
Bench uses CLKS_PER_BIT=4 and the queue model with show-ahead `dout`.
- Reset held 3 cycles with `q_empty`=0 → `q_pop`=0, `tx`=1, `busy`=0 throughout reset.
- Push 0xA5 → single `q_pop` pulse. After the start bit (`tx`=0 for 4 cycles), `tx` carries 1,0,1,0,0,1,0,1, each bit 4 cycles, then 4 cycles high. `busy` deasserts 40 cycles after `tx` falls.
- Push 0x00, 0xFF, 0x55 at once → 3 pops spaced exactly 41 cycles apart. Each byte is decoded correctly and the queue is empty after the third pop.
- `q_empty` held 1 for 200 cycles → no pop, `tx` constant 1, `busy` 0.
- Push 0x3C, then assert reset during data bit 3 → `tx`=1 and `busy`=0 one cycle later. A following push of 0x81 transmits a clean frame.
- With `UART_TX_PARITY_EN`, push 0x07 → parity bit 1 after the data bits. Pops for back-to-back bytes are spaced 45 cycles apart.
